// File: rtl/mac_dot_sequencer_if.sv
// mac_dot_sequencer_if
// Groups the job, operand and result handshake signals of the MAC dot-product
// sequencer. clk and rst stay plain ports on the sequencer itself.
//   start/len/busy                : job request and status
//   in_valid/in_ready/in_a/in_b   : operand-pair stream
//   out_valid/out_ready/out_data/out_ovf : result hand-off
// Modports: master = job/operand source and result consumer, slave = sequencer.
interface mac_dot_sequencer_if #(
    parameter int W     = 16,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
// Job controller for the 16-bit MAC datapath: accepts a job of len operand
// pairs, multiplies each pair in a registered stage, accumulates into an
// ACC_W-bit accumulator with a sticky carry-out flag, and hands one result
// per job to the consumer.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mac_dot_sequencer_if.slave (job, operand and result handshakes)
module mac_dot_sequencer #(
    parameter int W     = 16,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input logic                clk,
    input logic                rst,
    mac_dot_sequencer_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] p_q, p_d;
    logic             p_valid_q, p_valid_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum;

    assign accept = bus.in_valid && (state_q == RUN);
    // Extra top bit captures the carry out of the accumulator.
    assign sum    = {1'b0, acc_q} + {1'b0, p_q};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        p_valid_d = accept;
        acc_d     = acc_q;
        ovf_d     = ovf_q;

        // Accumulate stage runs regardless of state.
        if (p_valid_q) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
        end

        if (accept) begin
            p_d   = ACC_W'(bus.in_a) * ACC_W'(bus.in_b);
            cnt_d = cnt_q + LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (bus.len != '0) begin
                        len_d     = bus.len;
                        cnt_d     = '0;
                        p_valid_d = 1'b0;
                        state_d   = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept && (cnt_q == len_q - LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule
